// File: rtl/c7blsu_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : c7blsu_ctl
//  Purpose  : Load/store sequencer between the execute stage and the bus
//             interface unit. It accepts one memory op at a time from E,
//             checks alignment in LS1, runs a single-outstanding
//             request/ack/response bus transaction, and returns either
//             aligned and extended load data or a store-finish pulse in LS3.
//  Revision : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, resetn          : clock (rising edge), async active-low reset
//    lsu_*_e              : op issued from E (valid pulse plus op fields)
//    biu_req/we/addr/
//    biu_wstrb/wdata      : registered bus request, held stable until ack
//    biu_ack              : bus accepted the request this cycle
//    biu_resp_vld/rdata   : bus response (read data, or write done)
//    lsu_busy             : sequencer is not idle
//    lsu_except_ale_ls1   : one-cycle misaligned-address pulse
//    lsu_badv_ls1         : faulting address, valid with the ale pulse
//    lsu_data_valid_ls3   : one-cycle load completion pulse
//    lsu_wr_fin_ls3       : one-cycle store completion pulse
//    lsu_rdata_ls3/rd_ls3 : load result and destination register
// ============================================================================
module c7blsu_ctl (
  input  logic        clk,
  input  logic        resetn,
  // E-stage op
  input  logic        lsu_vld_e,
  input  logic        lsu_wen_e,
  input  logic [1:0]  lsu_size_e,
  input  logic        lsu_sext_e,
  input  logic [31:0] lsu_addr_e,
  input  logic [31:0] lsu_wdata_e,
  input  logic [4:0]  lsu_rd_e,
  // bus interface
  output logic        biu_req,
  output logic        biu_we,
  output logic [31:0] biu_addr,
  output logic [3:0]  biu_wstrb,
  output logic [31:0] biu_wdata,
  input  logic        biu_ack,
  input  logic        biu_resp_vld,
  input  logic [31:0] biu_rdata,
  // status, exception and completion
  output logic        lsu_busy,
  output logic        lsu_except_ale_ls1,
  output logic [31:0] lsu_badv_ls1,
  output logic        lsu_data_valid_ls3,
  output logic        lsu_wr_fin_ls3,
  output logic [31:0] lsu_rdata_ls3,
  output logic [4:0]  lsu_rd_ls3
);

  // Access sizes as encoded on lsu_size_e; 2'd3 behaves as a word.
  localparam logic [1:0] C_SIZE_BYTE = 2'd0;
  localparam logic [1:0] C_SIZE_HALF = 2'd1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LS1  = 3'd1,
    S_REQ  = 3'd2,
    S_RESP = 3'd3,
    S_LS3  = 3'd4
  } state_e;

  state_e      state_q;

  // Captured op fields
  logic        op_wen_q;
  logic [1:0]  op_size_q;
  logic        op_sext_q;
  logic [31:0] op_addr_q;
  logic [31:0] op_wdata_q;
  logic [4:0]  op_rd_q;

  // Registered outputs
  logic        biu_req_q;
  logic        biu_we_q;
  logic [31:0] biu_addr_q;
  logic [3:0]  biu_wstrb_q;
  logic [31:0] biu_wdata_q;
  logic        ale_q;
  logic [31:0] badv_q;
  logic        data_valid_q;
  logic        wr_fin_q;
  logic [31:0] rdata_ls3_q;
  logic [4:0]  rd_ls3_q;

  // Next-state values computed from inputs / captured fields
  logic        misalign_d;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;
  logic [31:0] ld_data_d;

  // --------------------------------------------------------------------------
  // Alignment check. It is evaluated on the E-stage fields so the ale pulse
  // can come straight out of a flop in the LS1 cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    misalign_d = 1'b0;
    case (lsu_size_e)
      C_SIZE_BYTE: misalign_d = 1'b0;
      C_SIZE_HALF: misalign_d = lsu_addr_e[0];
      default:     misalign_d = (lsu_addr_e[1:0] != 2'b00);
    endcase
  end

  // --------------------------------------------------------------------------
  // Store lane placement: strobes select the addressed bytes and the data is
  // replicated across all lanes so any strobe pattern finds its bytes.
  // --------------------------------------------------------------------------
  always_comb begin
    wstrb_d = 4'b0000;
    wdata_d = op_wdata_q;
    case (op_size_q)
      C_SIZE_BYTE: begin
        wstrb_d = 4'b0001 << op_addr_q[1:0];
        wdata_d = {4{op_wdata_q[7:0]}};
      end
      C_SIZE_HALF: begin
        wstrb_d = 4'b0011 << op_addr_q[1:0];
        wdata_d = {2{op_wdata_q[15:0]}};
      end
      default: begin
        wstrb_d = 4'b1111;
        wdata_d = op_wdata_q;
      end
    endcase
    if (!op_wen_q) begin
      wstrb_d = 4'b0000;
    end
  end

  // --------------------------------------------------------------------------
  // Load extraction: right-justify the addressed bytes, then extend. Word
  // accesses are aligned here, so the shift is zero and sext is irrelevant.
  // --------------------------------------------------------------------------
  logic [31:0] ld_shift;

  always_comb begin
    ld_shift  = biu_rdata >> {op_addr_q[1:0], 3'b000};
    ld_data_d = ld_shift;
    case (op_size_q)
      C_SIZE_BYTE: ld_data_d = {{24{op_sext_q & ld_shift[7]}},  ld_shift[7:0]};
      C_SIZE_HALF: ld_data_d = {{16{op_sext_q & ld_shift[15]}}, ld_shift[15:0]};
      default:     ld_data_d = ld_shift;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequencer. All outputs are registered here; completion and exception
  // strobes default low every cycle so they are single-cycle pulses.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      op_wen_q     <= 1'b0;
      op_size_q    <= 2'd0;
      op_sext_q    <= 1'b0;
      op_addr_q    <= 32'd0;
      op_wdata_q   <= 32'd0;
      op_rd_q      <= 5'd0;
      biu_req_q    <= 1'b0;
      biu_we_q     <= 1'b0;
      biu_addr_q   <= 32'd0;
      biu_wstrb_q  <= 4'd0;
      biu_wdata_q  <= 32'd0;
      ale_q        <= 1'b0;
      badv_q       <= 32'd0;
      data_valid_q <= 1'b0;
      wr_fin_q     <= 1'b0;
      rdata_ls3_q  <= 32'd0;
      rd_ls3_q     <= 5'd0;
    end else begin
      ale_q        <= 1'b0;
      data_valid_q <= 1'b0;
      wr_fin_q     <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (lsu_vld_e) begin
            op_wen_q   <= lsu_wen_e;
            op_size_q  <= lsu_size_e;
            op_sext_q  <= lsu_sext_e;
            op_addr_q  <= lsu_addr_e;
            op_wdata_q <= lsu_wdata_e;
            op_rd_q    <= lsu_rd_e;
            state_q    <= S_LS1;
            if (misalign_d) begin
              ale_q  <= 1'b1;
              badv_q <= lsu_addr_e;
            end
          end
        end

        S_LS1: begin
          // ale_q is high exactly when this op was found misaligned.
          if (ale_q) begin
            state_q <= S_IDLE;
          end else begin
            state_q     <= S_REQ;
            biu_req_q   <= 1'b1;
            biu_we_q    <= op_wen_q;
            biu_addr_q  <= op_addr_q;
            biu_wstrb_q <= wstrb_d;
            biu_wdata_q <= wdata_d;
          end
        end

        S_REQ: begin
          if (biu_ack) begin
            biu_req_q <= 1'b0;
            state_q   <= S_RESP;
          end
        end

        S_RESP: begin
          if (biu_resp_vld) begin
            state_q <= S_LS3;
            if (op_wen_q) begin
              wr_fin_q <= 1'b1;
            end else begin
              data_valid_q <= 1'b1;
              rdata_ls3_q  <= ld_data_d;
              rd_ls3_q     <= op_rd_q;
            end
          end
        end

        S_LS3: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign biu_req            = biu_req_q;
  assign biu_we             = biu_we_q;
  assign biu_addr           = biu_addr_q;
  assign biu_wstrb          = biu_wstrb_q;
  assign biu_wdata          = biu_wdata_q;
  assign lsu_busy           = (state_q != S_IDLE);
  assign lsu_except_ale_ls1 = ale_q;
  assign lsu_badv_ls1       = badv_q;
  assign lsu_data_valid_ls3 = data_valid_q;
  assign lsu_wr_fin_ls3     = wr_fin_q;
  assign lsu_rdata_ls3      = rdata_ls3_q;
  assign lsu_rd_ls3         = rd_ls3_q;

endmodule
`default_nettype wire

// File: tb/tb_c7blsu_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_c7blsu_ctl
//  Purpose  : Self-checking bench for c7blsu_ctl. Directed table of ops with
//             constant expectations, a reset-during-response sequence, and
//             random ops checked against a cycle-numbered reference model.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_c7blsu_ctl;

  logic        clk;
  logic        resetn;
  logic        lsu_vld_e;
  logic        lsu_wen_e;
  logic [1:0]  lsu_size_e;
  logic        lsu_sext_e;
  logic [31:0] lsu_addr_e;
  logic [31:0] lsu_wdata_e;
  logic [4:0]  lsu_rd_e;
  logic        biu_req;
  logic        biu_we;
  logic [31:0] biu_addr;
  logic [3:0]  biu_wstrb;
  logic [31:0] biu_wdata;
  logic        biu_ack;
  logic        biu_resp_vld;
  logic [31:0] biu_rdata;
  logic        lsu_busy;
  logic        lsu_except_ale_ls1;
  logic [31:0] lsu_badv_ls1;
  logic        lsu_data_valid_ls3;
  logic        lsu_wr_fin_ls3;
  logic [31:0] lsu_rdata_ls3;
  logic [4:0]  lsu_rd_ls3;

  c7blsu_ctl dut (
    .clk                (clk),
    .resetn             (resetn),
    .lsu_vld_e          (lsu_vld_e),
    .lsu_wen_e          (lsu_wen_e),
    .lsu_size_e         (lsu_size_e),
    .lsu_sext_e         (lsu_sext_e),
    .lsu_addr_e         (lsu_addr_e),
    .lsu_wdata_e        (lsu_wdata_e),
    .lsu_rd_e           (lsu_rd_e),
    .biu_req            (biu_req),
    .biu_we             (biu_we),
    .biu_addr           (biu_addr),
    .biu_wstrb          (biu_wstrb),
    .biu_wdata          (biu_wdata),
    .biu_ack            (biu_ack),
    .biu_resp_vld       (biu_resp_vld),
    .biu_rdata          (biu_rdata),
    .lsu_busy           (lsu_busy),
    .lsu_except_ale_ls1 (lsu_except_ale_ls1),
    .lsu_badv_ls1       (lsu_badv_ls1),
    .lsu_data_valid_ls3 (lsu_data_valid_ls3),
    .lsu_wr_fin_ls3     (lsu_wr_fin_ls3),
    .lsu_rdata_ls3      (lsu_rdata_ls3),
    .lsu_rd_ls3         (lsu_rd_ls3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One op with its bus behaviour and expected results.
  // aw = extra REQ cycles before ack, rw = extra RESP cycles before resp.
  typedef struct {
    logic        wen;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    int          aw;
    int          rw;
    logic [31:0] rdata;
    logic        exp_ale;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  int          total;
  int          bad;
  logic [31:0] last_rdata;
  logic [4:0]  last_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (plain arithmetic on the rules) --------
  function automatic logic m_ale(input logic [1:0] size, input logic [31:0] addr);
    int unsigned a;
    a = addr % 4;
    if (size == 2'd0) return 1'b0;
    if (size == 2'd1) return (a % 2) != 0;
    return a != 0;
  endfunction

  function automatic logic [3:0] m_wstrb(input logic wen, input logic [1:0] size,
                                         input logic [31:0] addr);
    int unsigned a;
    a = addr % 4;
    if (!wen) return 4'd0;
    if (size == 2'd0) return 4'(1 << a);
    if (size == 2'd1) return 4'(3 << a);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'd0) return (wd % 256) * 32'h0101_0101;
    if (size == 2'd1) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic sext,
                                         input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] sh;
    logic [31:0] v;
    sh = rdata / (32'd1 << (8 * (addr % 4)));
    if (size >= 2'd2) return rdata;
    if (size == 2'd0) begin
      v = sh % 256;
      if (sext && v >= 128) v = v + 32'hFFFF_FF00;
    end else begin
      v = sh % 65536;
      if (sext && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_req"},   {31'd0, biu_req}, 32'd0);
    chk({tag, "_we"},    {31'd0, biu_we}, 32'd0);
    chk({tag, "_addr"},  biu_addr, 32'd0);
    chk({tag, "_wstrb"}, {28'd0, biu_wstrb}, 32'd0);
    chk({tag, "_wdata"}, biu_wdata, 32'd0);
    chk({tag, "_busy"},  {31'd0, lsu_busy}, 32'd0);
    chk({tag, "_ale"},   {31'd0, lsu_except_ale_ls1}, 32'd0);
    chk({tag, "_badv"},  lsu_badv_ls1, 32'd0);
    chk({tag, "_dv"},    {31'd0, lsu_data_valid_ls3}, 32'd0);
    chk({tag, "_wf"},    {31'd0, lsu_wr_fin_ls3}, 32'd0);
    chk({tag, "_rdata"}, lsu_rdata_ls3, 32'd0);
    chk({tag, "_rd"},    {27'd0, lsu_rd_ls3}, 32'd0);
  endtask

  // Runs one op. Entered and left at a falling edge (start of cycle 0 / the
  // cycle after the last one), so ops run back to back at full rate.
  task automatic run_op(input vec_t v, input bit stray);
    bit mis;
    int last;
    bit req_e, dv_e, wf_e;
    mis  = v.exp_ale;
    last = mis ? 1 : 4 + v.aw + v.rw;

    chk("c0_busy", {31'd0, lsu_busy}, 32'd0);
    lsu_vld_e    = 1'b1;
    lsu_wen_e    = v.wen;
    lsu_size_e   = v.size;
    lsu_sext_e   = v.sext;
    lsu_addr_e   = v.addr;
    lsu_wdata_e  = v.wdata;
    lsu_rd_e     = v.rd;
    biu_ack      = 1'b0;
    biu_resp_vld = stray;
    biu_rdata    = $urandom();

    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      lsu_vld_e   = 1'b0;
      lsu_addr_e  = $urandom();
      lsu_wdata_e = $urandom();
      lsu_size_e  = 2'($urandom_range(0, 3));

      req_e = !mis && (c >= 2) && (c <= 2 + v.aw);
      dv_e  = !mis && !v.wen && (c == last);
      wf_e  = !mis &&  v.wen && (c == last);

      chk("ale",  {31'd0, lsu_except_ale_ls1}, {31'd0, mis && (c == 1)});
      if (mis && c == 1) chk("badv", lsu_badv_ls1, v.addr);
      chk("req",  {31'd0, biu_req}, {31'd0, req_e});
      if (req_e) begin
        chk("we",    {31'd0, biu_we}, {31'd0, v.wen});
        chk("addr",  biu_addr, v.addr);
        chk("wstrb", {28'd0, biu_wstrb}, {28'd0, v.exp_wstrb});
        if (v.wen) chk("wdata", biu_wdata, v.exp_wdata);
      end
      chk("busy", {31'd0, lsu_busy}, 32'd1);
      chk("dv",   {31'd0, lsu_data_valid_ls3}, {31'd0, dv_e});
      chk("wf",   {31'd0, lsu_wr_fin_ls3}, {31'd0, wf_e});
      if (dv_e) begin
        last_rdata = v.exp_rdata;
        last_rd    = v.rd;
      end
      // Load result must show the new value on the pulse and hold otherwise.
      chk("rdata_ls3", lsu_rdata_ls3, last_rdata);
      chk("rd_ls3", {27'd0, lsu_rd_ls3}, {27'd0, last_rd});

      biu_ack      = !mis && (c == 2 + v.aw);
      biu_resp_vld = (!mis && (c == 3 + v.aw + v.rw)) ||
                     (stray && (mis || c <= 2 + v.aw || c == last));
      biu_rdata    = (!mis && (c == 3 + v.aw + v.rw)) ? v.rdata : $urandom();
    end
    @(negedge clk);
    biu_ack      = 1'b0;
    biu_resp_vld = 1'b0;
  endtask

  vec_t tbl [11];
  vec_t r;

  function automatic vec_t mk(input logic wen, input logic [1:0] size, input logic sext,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [4:0] rd, input int aw, input int rw,
                              input logic [31:0] rdata, input logic e_ale,
                              input logic [3:0] e_wstrb, input logic [31:0] e_wdata,
                              input logic [31:0] e_rdata);
    vec_t t;
    t.wen = wen; t.size = size; t.sext = sext; t.addr = addr; t.wdata = wdata;
    t.rd = rd; t.aw = aw; t.rw = rw; t.rdata = rdata; t.exp_ale = e_ale;
    t.exp_wstrb = e_wstrb; t.exp_wdata = e_wdata; t.exp_rdata = e_rdata;
    return t;
  endfunction

  initial begin
    total = 0; bad = 0; last_rdata = 32'd0; last_rd = 5'd0;
    resetn = 1'b0; lsu_vld_e = 1'b0; lsu_wen_e = 1'b0; lsu_size_e = 2'd0;
    lsu_sext_e = 1'b0; lsu_addr_e = 32'd0; lsu_wdata_e = 32'd0; lsu_rd_e = 5'd0;
    biu_ack = 1'b0; biu_resp_vld = 1'b0; biu_rdata = 32'd0;

    //            wen  sz   sx  addr          wdata         rd  aw rw rdata         ale wstrb  exp_wdata     exp_rdata
    tbl[0]  = mk(1'b0, 2'd2, 0, 32'h0000_1000, 32'h0,        5,  0, 0, 32'hDEAD_BEEF, 0, 4'h0, 32'h0,        32'hDEAD_BEEF);
    tbl[1]  = mk(1'b0, 2'd0, 1, 32'h0000_1003, 32'h0,        9,  0, 0, 32'h80FF_0011, 0, 4'h0, 32'h0,        32'hFFFF_FF80);
    tbl[2]  = mk(1'b0, 2'd0, 0, 32'h0000_1003, 32'h0,        10, 0, 0, 32'h80FF_0011, 0, 4'h0, 32'h0,        32'h0000_0080);
    tbl[3]  = mk(1'b1, 2'd1, 0, 32'h0000_2002, 32'h1234_ABCD, 0, 0, 0, 32'h0,         0, 4'hC, 32'hABCD_ABCD, 32'h0);
    tbl[4]  = mk(1'b0, 2'd2, 0, 32'h0000_1002, 32'h0,        3,  0, 0, 32'h0,         1, 4'h0, 32'h0,        32'h0);
    tbl[5]  = mk(1'b0, 2'd2, 0, 32'h0000_5004, 32'h0,        17, 3, 2, 32'h0BAD_F00D, 0, 4'h0, 32'h0,        32'h0BAD_F00D);
    tbl[6]  = mk(1'b0, 2'd1, 1, 32'h0000_1002, 32'h0,        31, 1, 0, 32'h8001_0000, 0, 4'h0, 32'h0,        32'hFFFF_8001);
    tbl[7]  = mk(1'b1, 2'd0, 0, 32'h0000_3001, 32'h0000_0055, 0, 0, 1, 32'h0,         0, 4'h2, 32'h5555_5555, 32'h0);
    tbl[8]  = mk(1'b1, 2'd3, 0, 32'h0000_4000, 32'hCAFE_F00D, 0, 2, 0, 32'h0,         0, 4'hF, 32'hCAFE_F00D, 32'h0);
    tbl[9]  = mk(1'b1, 2'd1, 0, 32'h0000_2001, 32'h0,        0,  0, 0, 32'h0,         1, 4'h0, 32'h0,        32'h0);
    tbl[10] = mk(1'b0, 2'd0, 0, 32'h0000_1001, 32'h0,        12, 0, 0, 32'h1234_5678, 0, 4'h0, 32'h0,        32'h0000_0056);

    repeat (3) @(negedge clk);
    chk_zero("rst");
    resetn = 1'b1;

    for (int i = 0; i < 11; i++) run_op(tbl[i], 1'b0);

    // Reset asserted while waiting for the response.
    lsu_vld_e = 1'b1; lsu_wen_e = 1'b0; lsu_size_e = 2'd2; lsu_sext_e = 1'b0;
    lsu_addr_e = 32'h0000_1000; lsu_rd_e = 5'd7;
    @(negedge clk); lsu_vld_e = 1'b0;
    @(negedge clk); chk("mr_req", {31'd0, biu_req}, 32'd1); biu_ack = 1'b1;
    @(negedge clk); biu_ack = 1'b0;
    chk("mr_req_off", {31'd0, biu_req}, 32'd0);
    chk("mr_busy", {31'd0, lsu_busy}, 32'd1);
    resetn = 1'b0;
    #1;
    chk_zero("mr");
    last_rdata = 32'd0; last_rd = 5'd0;
    @(negedge clk); resetn = 1'b1; biu_resp_vld = 1'b1; biu_rdata = 32'h1111_2222;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stray_dv", {31'd0, lsu_data_valid_ls3}, 32'd0);
      chk("stray_wf", {31'd0, lsu_wr_fin_ls3}, 32'd0);
      chk("stray_busy", {31'd0, lsu_busy}, 32'd0);
    end
    biu_resp_vld = 1'b0;
    run_op(mk(1'b0, 2'd2, 0, 32'h0000_0040, 32'h0, 6, 0, 0, 32'h7654_3210,
              0, 4'h0, 32'h0, 32'h7654_3210), 1'b0);

    // Random ops against the model.
    for (int n = 0; n < 200; n++) begin
      r.wen   = 1'($urandom_range(0, 1));
      r.size  = 2'($urandom_range(0, 3));
      r.sext  = 1'($urandom_range(0, 1));
      r.addr  = $urandom();
      if ($urandom_range(0, 3) != 0) begin
        if (r.size == 2'd1) r.addr[0] = 1'b0;
        else if (r.size != 2'd0) r.addr[1:0] = 2'b00;
      end
      r.wdata = $urandom();
      r.rd    = 5'($urandom_range(0, 31));
      r.aw    = $urandom_range(0, 3);
      r.rw    = $urandom_range(0, 3);
      r.rdata = $urandom();
      r.exp_ale   = m_ale(r.size, r.addr);
      r.exp_wstrb = m_wstrb(r.wen, r.size, r.addr);
      r.exp_wdata = m_wdata(r.size, r.wdata);
      r.exp_rdata = m_load(r.size, r.sext, r.addr, r.rdata);
      run_op(r, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/c7blsu_ctl.md
# c7blsu_ctl

Load/store sequencer that services memory ops issued from the E stage and produces the completion and exception strobes consumed by the execute-stage stall control (`lsu_except_ale_ls1`, `lsu_data_valid_ls3`, `lsu_wr_fin_ls3`). It checks alignment in LS1 and drives a single-outstanding request/acknowledge/response bus interface. It returns aligned and extended load data, or a store-finish pulse, in LS3. It sits between the execute unit and the bus interface unit, one op in flight at a time.

## Interface
- No parameters. Data and address width are fixed at 32.
- `clk` input 1: sole clock, rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `lsu_vld_e` input 1: memory op valid in E; one-cycle pulse.
- `lsu_wen_e` input 1: 1 = store, 0 = load.
- `lsu_size_e` input 2: 0 = byte, 1 = half, 2 = word, 3 = treated as word.
- `lsu_sext_e` input 1: sign-extend load result.
- `lsu_addr_e` input 32: byte address.
- `lsu_wdata_e` input 32: store data, right-justified.
- `lsu_rd_e` input 5: load destination register.
- `biu_req` output 1: bus request.
- `biu_we` output 1: request is a write.
- `biu_addr` output 32: full byte address.
- `biu_wstrb` output 4: byte write strobes.
- `biu_wdata` output 32: lane-replicated store data.
- `biu_ack` input 1: bus accepted the request this cycle.
- `biu_resp_vld` input 1: read data valid, or write done.
- `biu_rdata` input 32: read word.
- `lsu_busy` output 1: state is not IDLE.
- `lsu_except_ale_ls1` output 1: misaligned-address pulse.
- `lsu_badv_ls1` output 32: faulting address; valid with the ale pulse.
- `lsu_data_valid_ls3` output 1: load completion pulse.
- `lsu_wr_fin_ls3` output 1: store completion pulse.
- `lsu_rdata_ls3` output 32: extended load result.
- `lsu_rd_ls3` output 5: destination register for `lsu_rdata_ls3`.

## Operation
- FSM states: IDLE, LS1, REQ, RESP, LS3.
- IDLE: on `lsu_vld_e`, register the op fields (wen, size, sext, addr, wdata, rd) and go to LS1. `lsu_vld_e` arriving in any other state is ignored; upstream stall guarantees it does not occur.
- LS1 alignment rules:
  - Half is misaligned when addr[0] = 1.
  - Word (size 2 or 3) is misaligned when addr[1:0] ≠ 0.
  - Byte is never misaligned.
- LS1 on misalignment: `lsu_except_ale_ls1` = 1 and `lsu_badv_ls1` = addr for this one cycle, then go to IDLE. No bus activity occurs.
- LS1 when aligned: go to REQ.
- REQ: `biu_req` = 1, with `biu_we`, `biu_addr`, `biu_wstrb`, `biu_wdata` held stable until `biu_ack`. On `biu_ack`, go to RESP.
- RESP: `biu_req` = 0. Wait for `biu_resp_vld`; on it, capture `biu_rdata` and go to LS3. `biu_resp_vld` outside RESP is ignored.
- LS3: for one cycle, pulse `lsu_data_valid_ls3` (load) or `lsu_wr_fin_ls3` (store), then go to IDLE. Never both.
- Store strobes and data, with o = addr[1:0]:
  - Byte: `biu_wstrb` = 4'b0001 << o; `biu_wdata` = the byte replicated ×4.
  - Half: `biu_wstrb` = 4'b0011 << o; `biu_wdata` = the half replicated ×2.
  - Word: `biu_wstrb` = 4'b1111; `biu_wdata` as given.
  - `biu_wstrb` = 0 for loads.
- Load result: shift = rdata >> (8 × addr[1:0]). Byte or half is then zero- or sign-extended per sext. Word passes unchanged and ignores sext.
- `lsu_rdata_ls3` and `lsu_rd_ls3` are valid only while `lsu_data_valid_ls3` is 1; otherwise they hold their last value.

## Timing
- Reset: state = IDLE. All outputs are 0, including registered data outputs. Reset is asynchronous, so asserting it mid-op drops `biu_req` and all pulses immediately. Any outstanding bus transaction is abandoned; the bus side is reset by the same `resetn`.
- Cycle numbering, op accepted at cycle 0:
  - Misaligned: ale pulse at cycle 1.
  - Aligned, zero-wait bus: REQ at cycle 2 (ack same cycle), RESP at cycle 3 (resp same cycle), completion pulse at cycle 4.
- Each bus wait cycle adds exactly one cycle of latency.
- `lsu_busy` is 1 from cycle 1 through the LS3 cycle inclusive.
- Back-to-back ops: the earliest next `lsu_vld_e` is accepted in the cycle after LS3, or the cycle after the ale pulse.

## Test plan
- Word load at 0x0000_1000, rd = 5, ack and resp immediate, rdata = 0xDEADBEEF -> `biu_req` at cycle 2 with wstrb = 0; `lsu_data_valid_ls3` = 1 at cycle 4 with rdata_ls3 = 0xDEADBEEF and rd_ls3 = 5; `lsu_wr_fin_ls3` stays 0.
- Byte load at 0x1003, rdata = 0x80FF_0011 -> with sext = 1, rdata_ls3 = 0xFFFF_FF80; repeated with sext = 0, rdata_ls3 = 0x0000_0080.
- Half store at 0x2002, wdata = 0x1234_ABCD -> biu_we = 1, wstrb = 4'b1100, biu_wdata = 0xABCD_ABCD; `lsu_wr_fin_ls3` pulses for one cycle after resp; `lsu_data_valid_ls3` stays 0.
- Word load at 0x1002 -> `lsu_except_ale_ls1` = 1 at cycle 1 with badv = 0x1002; `biu_req` never asserts; state returns to IDLE at cycle 2.
- Aligned load with ack in the 4th REQ cycle and resp in the 3rd RESP cycle -> `biu_req` high for cycles 2–5 with fields stable; completion pulse at cycle 9.
- `resetn` low during RESP -> all outputs 0 at once. After release, a new word load completes at the 4-cycle latency; a stray `biu_resp_vld` in IDLE produces no pulse.
